lynx_io_ctrl: RTL and testbench
===============================

// Module: lynx_io_ctrl
// PURPOSE
//  Z80 I/O port controller directly downstream of the cpu wrapper; consumes its mreq/iorq/wr/a/data_out bus.
//  Decodes I/O cycles, latches the control and speaker-DAC write ports, and returns keyboard data on reads.
//  Generates the frame interrupt (int_n) fed back to the cpu from the video vsync.
// PARAMETERS
//  PORT_CTRL   8'h80  control port address (A[7:0] after mask)
//  PORT_DAC    8'h84  speaker DAC port address
//  DECODE_MASK 8'hC7  A[7:0] bits compared during decode (partial decode)
//  INT_LEN     32     int_n low time in cep cycles (>=1)
// PORTS
//  clock        in   1   system clock; single domain
//  reset        in   1   asynchronous, active-low reset
//  cep          in   1   cpu clock enable (same strobe given to the cpu)
//  iorq         in   1   cpu IORQ_n, active low
//  mreq         in   1   cpu MREQ_n, active low (used only to qualify: I/O ignored if mreq low)
//  wr           in   1   cpu WR_n, active low
//  a            in   16  cpu address bus
//  cpu_do       in   8   cpu write data (data_out)
//  vsync        in   1   video vsync, asynchronous to cep phase
//  kb_data      in   8   keyboard column data, active low, for row kb_row
//  kb_row       out  4   keyboard row select = a[11:8] during I/O read (else 4'hF)
//  io_rd_en     out  1   1 = io_rd_data must be muxed onto cpu di
//  io_rd_data   out  8   read data
//  ctrl_reg     out  8   control port latch (bank/video bits; bit 7 = INT_MASK)
//  dac_reg      out  6   speaker DAC latch (cpu_do[5:0])
//  io_wr_stb    out  1   one-clock pulse per accepted I/O write
//  int_n        out  1   frame interrupt to cpu, active low
// BEHAVIOUR
//  Reset (async, reset=0): ctrl_reg=8'h00, dac_reg=0, io_wr_stb=0, int_n=1, int counter=0, sync FFs=0.
//  Decode: hit_X = ((a[7:0] & DECODE_MASK) == (PORT_X & DECODE_MASK)) && !iorq && mreq.
//  Write: wr_act = !iorq && mreq && !wr. Registered wr_act_q updated on cep cycles only.
//   Accept on the first cep cycle with wr_act=1 and wr_act_q=0: latch reg for the hit port,
//   pulse io_wr_stb for exactly 1 clock. Remaining cycles of the same write are ignored.
//   Write to unmapped port: io_wr_stb still pulses, no register changes.
//  Read: combinational. io_rd_en = !iorq && mreq && wr && hit_CTRL; io_rd_data = kb_data; kb_row=a[11:8].
//   DAC port is write-only (io_rd_en=0). When io_rd_en=0, io_rd_data=8'hFF.
//  Interrupt FSM (states IDLE, ACTIVE), advances only on cep:
//   vsync -> 2-FF synchroniser -> rising-edge detect (edge held until next cep if it arrives between ceps).
//   IDLE: edge && !INT_MASK -> ACTIVE, cnt=INT_LEN-1, int_n=0.
//   ACTIVE: cnt==0 -> IDLE, int_n=1; else cnt--.
//   New edge during ACTIVE restarts cnt=INT_LEN-1 (no gap in int_n).
//   INT_MASK set while ACTIVE -> IDLE, int_n=1 on the next cep cycle.
//   Edge and mask-write in same cep cycle: mask wins (no interrupt).
//  Counter width = $clog2(INT_LEN+1); no wrap: cnt never decremented below 0.
//  Reset mid-operation returns to IDLE immediately, int_n=1; a pending vsync edge is discarded.
//  Latency: register visible 1 clock after accepting cep; int_n low 2-3 clocks + <=1 cep after vsync rise.
// STRUCTURE
//  Package lynx_io_pkg: PORT_* defaults, CTRL_INT_MASK_BIT=7, int FSM state enum.
//  Sub-module sync_edge: 2-FF synchroniser + rising-edge pulse (reused for other async inputs).
//  Top holds decode, write latches, read mux, int FSM.
// TESTING
//  OUT (0x80),0x5A then OUT (0x84),0x3F -> ctrl_reg=8'h5A, dac_reg=6'h3F, two io_wr_stb 1-clk pulses.
//  Write held 4 cep cycles to 0x84 with data changing 0x01->0x02 -> one io_wr_stb, dac_reg=6'h01.
//  IN a=16'h0380, kb_data=8'hFE -> io_rd_en=1, kb_row=4'h3, io_rd_data=8'hFE; a=0x0384 -> io_rd_en=0, 8'hFF.
//  vsync rise, INT_LEN=32 -> int_n low exactly 32 cep cycles; 2nd rise at cep 20 -> low 52 ceps in total.
//  ctrl_reg[7]=1 then vsync rise -> int_n stays 1; set mask at cep 10 of pulse -> int_n=1 next cep.
//  reset=0 asserted mid-pulse and mid-write -> int_n=1, ctrl_reg=0, dac_reg=0 without a clock edge.

Source files
------------

// File: rtl/lynx_io_pkg.sv
// Shared definitions for the Lynx I/O port controller.
// Holds the default port addresses, the decode mask, the interrupt length,
// the control-register bit that masks the frame interrupt, the interrupt
// FSM state type and the port-decode helper.
package lynx_io_pkg;

    localparam logic [7:0] PORT_CTRL_DEF   = 8'h80;
    localparam logic [7:0] PORT_DAC_DEF    = 8'h84;
    localparam logic [7:0] DECODE_MASK_DEF = 8'hC7;
    localparam int         INT_LEN_DEF     = 32;
    localparam int         CTRL_INT_MASK_BIT = 7;

    typedef enum logic {
        INT_IDLE,
        INT_ACTIVE
    } int_state_e;

    // Partial decode: only the address bits selected by mask take part.
    function automatic logic port_hit(
        input logic [7:0] addr,
        input logic [7:0] port,
        input logic [7:0] mask
    );
        return (addr & mask) == (port & mask);
    endfunction

endpackage

// File: rtl/lynx_io_ctrl_sync_edge.sv
// sync_edge: two-flop synchroniser for an asynchronous level input followed
// by a rising-edge detector. rise_o is a one-clock pulse.
// Ports:
//   clock  in  system clock
//   reset  in  asynchronous active-low reset (clears all flops)
//   din_i  in  asynchronous input level
//   rise_o out one-clock pulse on a synchronised 0->1 transition
module sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic din_i,
    output logic rise_o
);

    // [0] metastability flop, [1] synchronised level, [2] previous level.
    logic [2:0] sync_q;

    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], din_i};
        end
    end

    assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/lynx_io_ctrl.sv
// lynx_io_ctrl: Z80 I/O port controller.
// Decodes I/O cycles from the cpu bus, latches the control and speaker-DAC
// write ports, returns keyboard data on control-port reads and generates the
// frame interrupt from video vsync.
// Ports:
//   clock, reset      system clock, asynchronous active-low reset
//   cep               cpu clock enable
//   iorq, mreq, wr    cpu bus strobes (active low)
//   a, cpu_do         cpu address bus, cpu write data
//   vsync             video vsync (asynchronous)
//   kb_data, kb_row   keyboard column data in, row select out
//   io_rd_en          io_rd_data must be muxed onto the cpu data-in bus
//   io_rd_data        read data
//   ctrl_reg, dac_reg control and speaker-DAC latches
//   io_wr_stb         one-clock pulse per accepted I/O write
//   int_n             frame interrupt, active low
module lynx_io_ctrl
    import lynx_io_pkg::*;
#(
    parameter logic [7:0] PORT_CTRL   = PORT_CTRL_DEF,
    parameter logic [7:0] PORT_DAC    = PORT_DAC_DEF,
    parameter logic [7:0] DECODE_MASK = DECODE_MASK_DEF,
    parameter int         INT_LEN     = INT_LEN_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cep,
    input  logic        iorq,
    input  logic        mreq,
    input  logic        wr,
    input  logic [15:0] a,
    input  logic [7:0]  cpu_do,
    input  logic        vsync,
    input  logic [7:0]  kb_data,
    output logic [3:0]  kb_row,
    output logic        io_rd_en,
    output logic [7:0]  io_rd_data,
    output logic [7:0]  ctrl_reg,
    output logic [5:0]  dac_reg,
    output logic        io_wr_stb,
    output logic        int_n
);

    localparam int CNT_W = $clog2(INT_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INT_LEN - 1);

    // ---------------- decode ----------------
    logic io_cyc, hit_ctrl, hit_dac, wr_act, rd_act, accept;
    logic unused_a;

    assign io_cyc   = !iorq && mreq;
    assign hit_ctrl = io_cyc && port_hit(a[7:0], PORT_CTRL, DECODE_MASK);
    assign hit_dac  = io_cyc && port_hit(a[7:0], PORT_DAC, DECODE_MASK);
    assign wr_act   = io_cyc && !wr;
    assign rd_act   = io_cyc && wr;
    assign unused_a = ^a[15:12];

    // ---------------- write latches ----------------
    logic       wr_act_q;
    logic [7:0] ctrl_q, ctrl_d;
    logic [5:0] dac_q, dac_d;
    logic       stb_q;

    // Only the first cep cycle of a write is taken; the rest of the same
    // bus cycle is ignored even if the data changes.
    assign accept = cep && wr_act && !wr_act_q;

    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        ctrl_d = ctrl_q;
        dac_d  = dac_q;
        if (accept && hit_ctrl) ctrl_d = cpu_do;
        if (accept && hit_dac)  dac_d  = cpu_do[5:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_act_q <= 1'b0;
            ctrl_q   <= 8'h00;
            dac_q    <= 6'h00;
            stb_q    <= 1'b0;
        end else begin
            if (cep) wr_act_q <= wr_act;
            ctrl_q <= ctrl_d;
            dac_q  <= dac_d;
            stb_q  <= accept;
        end
    end

    assign ctrl_reg  = ctrl_q;
    assign dac_reg   = dac_q;
    assign io_wr_stb = stb_q;

    // ---------------- read path (combinational) ----------------
    // The DAC port is write-only, so only the control address returns data.
    assign io_rd_en   = rd_act && hit_ctrl;
    assign io_rd_data = io_rd_en ? kb_data : 8'hFF;
    assign kb_row     = rd_act ? a[11:8] : 4'hF;

    // ---------------- frame interrupt ----------------
    logic vs_rise, edge_pend_q, edge_seen, mask_d;

    sync_edge u_vsync_sync (
        .clock  (clock),
        .reset  (reset),
        .din_i  (vsync),
        .rise_o (vs_rise)
    );

    // A rise arriving between ceps is held until the next cep consumes it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            edge_pend_q <= 1'b0;
        end else if (cep) begin
            edge_pend_q <= 1'b0;
        end else if (vs_rise) begin
            edge_pend_q <= 1'b1;
        end
    end

    assign edge_seen = vs_rise || edge_pend_q;
    // Looking at the post-write mask lets a mask write in the same cep cycle
    // as an edge suppress that interrupt.
    assign mask_d    = ctrl_d[CTRL_INT_MASK_BIT];

    int_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic           int_n_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= INT_IDLE;
            cnt_q   <= '0;
            int_n_q <= 1'b1;
        end else if (cep) begin
            case (state_q)
                INT_IDLE: begin
                    if (edge_seen && !mask_d) begin
                        state_q <= INT_ACTIVE;
                        cnt_q   <= CNT_LOAD;
                        int_n_q <= 1'b0;
                    end
                end
                INT_ACTIVE: begin
                    if (ctrl_q[CTRL_INT_MASK_BIT]) begin
                        state_q <= INT_IDLE;
                        int_n_q <= 1'b1;
                    end else if (edge_seen && !mask_d) begin
                        cnt_q <= CNT_LOAD;
                    end else if (cnt_q == '0) begin
                        state_q <= INT_IDLE;
                        int_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= INT_IDLE;
                    int_n_q <= 1'b1;
                end
            endcase
        end
    end

    assign int_n = int_n_q;

endmodule

// File: tb/tb_lynx_io_ctrl.sv
// Directed testbench for lynx_io_ctrl.
module tb_lynx_io_ctrl;

    logic        clock   = 1'b0;
    logic        reset   = 1'b1;
    logic        cep     = 1'b0;
    logic        iorq    = 1'b1;
    logic        mreq    = 1'b1;
    logic        wr      = 1'b1;
    logic [15:0] a       = 16'h0000;
    logic [7:0]  cpu_do  = 8'h00;
    logic        vsync   = 1'b0;
    logic [7:0]  kb_data = 8'hFF;
    logic [3:0]  kb_row;
    logic        io_rd_en;
    logic [7:0]  io_rd_data;
    logic [7:0]  ctrl_reg;
    logic [5:0]  dac_reg;
    logic        io_wr_stb;
    logic        int_n;

    bit cep_run = 1'b1;
    int n_checks = 0;
    int n_errors = 0;
    int stb_cnt = 0;   // clocks with io_wr_stb high
    int low_cnt = 0;   // cep cycles entered with int_n low

    lynx_io_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .cep        (cep),
        .iorq       (iorq),
        .mreq       (mreq),
        .wr         (wr),
        .a          (a),
        .cpu_do     (cpu_do),
        .vsync      (vsync),
        .kb_data    (kb_data),
        .kb_row     (kb_row),
        .io_rd_en   (io_rd_en),
        .io_rd_data (io_rd_data),
        .ctrl_reg   (ctrl_reg),
        .dac_reg    (dac_reg),
        .io_wr_stb  (io_wr_stb),
        .int_n      (int_n)
    );

    always #5 clock = ~clock;

    // cep high on every other clock while cep_run is set; changes 2 units
    // after the rising edge so it is stable at the next one.
    always @(posedge clock) begin
        #2;
        cep = cep_run ? ~cep : 1'b0;
    end

    always @(negedge clock) begin
        if (io_wr_stb) stb_cnt++;
        if (cep && !int_n) low_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next clock edge that has cep high.
    task automatic step_cep();
        int g;
        g = 0;
        @(posedge clock);
        while (!cep && g < 8) begin
            @(posedge clock);
            g++;
        end
        if (!cep) check("cep_timeout", 32'd0, 32'd1);
        #3;
    endtask

    task automatic write_io(input logic [15:0] addr, input logic [7:0] data, input int n);
        a      = addr;
        cpu_do = data;
        iorq   = 1'b0;
        wr     = 1'b0;
        repeat (n) step_cep();
        iorq = 1'b1;
        wr   = 1'b1;
        step_cep();
    endtask

    // Raise vsync with cep stopped so the synchronised edge is pending when
    // cep restarts; the next step_cep is the consuming cep cycle.
    task automatic start_edge();
        cep_run = 1'b0;
        @(posedge clock);
        #3;
        vsync = 1'b1;
        repeat (4) @(posedge clock);
        #3;
        cep_run = 1'b1;
    endtask

    initial begin
        #2 reset = 1'b0;
        #20;
        check("rst_int_n", int_n, 1);
        check("rst_ctrl", ctrl_reg, 8'h00);
        check("rst_dac", dac_reg, 6'h00);
        check("rst_stb", io_wr_stb, 0);
        check("rst_kb_row", kb_row, 4'hF);
        check("rst_rd_en", io_rd_en, 0);
        check("rst_rd_data", io_rd_data, 8'hFF);
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #3;

        // Two single writes.
        stb_cnt = 0;
        write_io(16'h0080, 8'h5A, 1);
        write_io(16'h0084, 8'h3F, 1);
        check("wr_ctrl", ctrl_reg, 8'h5A);
        check("wr_dac", dac_reg, 6'h3F);
        check("wr_stb_cnt", stb_cnt, 2);

        // Held write with changing data: first cep only.
        stb_cnt = 0;
        a = 16'h0084; cpu_do = 8'h01; iorq = 1'b0; wr = 1'b0;
        repeat (2) step_cep();
        cpu_do = 8'h02;
        repeat (2) step_cep();
        iorq = 1'b1; wr = 1'b1;
        step_cep();
        check("held_dac", dac_reg, 6'h01);
        check("held_stb", stb_cnt, 1);

        // Partial decode aliases.
        write_io(16'h12B8, 8'hA5, 1);
        check("alias_ctrl", ctrl_reg, 8'hA5);
        write_io(16'h0094, 8'h2A, 1);
        check("alias_dac", dac_reg, 6'h2A);

        // Unmapped port: strobe but no register change.
        stb_cnt = 0;
        write_io(16'h0081, 8'h11, 1);
        check("unmap_stb", stb_cnt, 1);
        check("unmap_ctrl", ctrl_reg, 8'hA5);
        check("unmap_dac", dac_reg, 6'h2A);

        // mreq low disqualifies the cycle.
        stb_cnt = 0;
        mreq = 1'b0;
        write_io(16'h0080, 8'h00, 1);
        mreq = 1'b1;
        check("mreq_stb", stb_cnt, 0);
        check("mreq_ctrl", ctrl_reg, 8'hA5);

        // Reads.
        a = 16'h0380; kb_data = 8'hFE; iorq = 1'b0; wr = 1'b1;
        #1;
        check("rd_en", io_rd_en, 1);
        check("rd_row", kb_row, 4'h3);
        check("rd_data", io_rd_data, 8'hFE);
        a = 16'h0384;
        #1;
        check("rd_dac_en", io_rd_en, 0);
        check("rd_dac_data", io_rd_data, 8'hFF);
        mreq = 1'b0; a = 16'h0380;
        #1;
        check("rd_mreq_en", io_rd_en, 0);
        mreq = 1'b1; iorq = 1'b1;
        #1;
        check("rd_idle_row", kb_row, 4'hF);
        check("rd_idle_data", io_rd_data, 8'hFF);
        kb_data = 8'hFF;

        // Unmask the interrupt.
        write_io(16'h0080, 8'h05, 1);

        // Single vsync rise: 32 cep cycles low.
        low_cnt = 0;
        start_edge();
        step_cep();
        check("int_low_start", int_n, 0);
        vsync = 1'b0;
        repeat (79) step_cep();
        check("int_len", low_cnt, 32);
        check("int_end", int_n, 1);

        // Second rise at cep 20 of the pulse: 52 in total.
        low_cnt = 0;
        start_edge();
        step_cep();
        vsync = 1'b0;
        repeat (19) step_cep();
        start_edge();
        step_cep();
        vsync = 1'b0;
        repeat (80) step_cep();
        check("int_restart_len", low_cnt, 52);

        // Mask written at cep 10 of the pulse.
        start_edge();
        step_cep();
        vsync = 1'b0;
        repeat (9) step_cep();
        check("int_before_mask", int_n, 0);
        write_io(16'h0080, 8'h85, 1);
        check("int_mask_stop", int_n, 1);

        // Masked: no interrupt at all.
        low_cnt = 0;
        start_edge();
        step_cep();
        vsync = 1'b0;
        repeat (40) step_cep();
        check("int_masked", low_cnt, 0);

        // Edge and mask write in the same cep cycle: mask wins.
        write_io(16'h0080, 8'h05, 1);
        low_cnt = 0;
        cep_run = 1'b0;
        @(posedge clock);
        #3;
        vsync = 1'b1;
        repeat (4) @(posedge clock);
        #3;
        a = 16'h0080; cpu_do = 8'h80; iorq = 1'b0; wr = 1'b0;
        cep_run = 1'b1;
        step_cep();
        iorq = 1'b1; wr = 1'b1;
        vsync = 1'b0;
        repeat (40) step_cep();
        check("mask_wins_low", low_cnt, 0);
        check("mask_wins_ctrl", ctrl_reg, 8'h80);

        // Reset mid-pulse and mid-write.
        write_io(16'h0080, 8'h05, 1);
        write_io(16'h0084, 8'h15, 1);
        start_edge();
        step_cep();
        vsync = 1'b0;
        repeat (5) step_cep();
        check("pre_rst_int", int_n, 0);
        a = 16'h0084; cpu_do = 8'h2C; iorq = 1'b0; wr = 1'b0;
        vsync = 1'b1;
        @(posedge clock);
        #5 reset = 1'b0;
        #1;
        check("mid_rst_int_n", int_n, 1);
        check("mid_rst_ctrl", ctrl_reg, 8'h00);
        check("mid_rst_dac", dac_reg, 6'h00);
        check("mid_rst_stb", io_wr_stb, 0);
        iorq = 1'b1; wr = 1'b1; vsync = 1'b0;
        #2 reset = 1'b1;
        low_cnt = 0;
        repeat (40) step_cep();
        check("post_rst_low", low_cnt, 0);
        check("post_rst_ctrl", ctrl_reg, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
